host_cmd_master: RTL and testbench
==================================

# host_cmd_master

Host-side command initiator for the UART-driven low-power system. It turns one parallel command request into the byte frame the system controller decodes: register-file write `AA`, register-file read `BB`, ALU op with operands `CC`, ALU op without operands `DD`. It drives those bytes into the UART transmitter, then collects and reassembles the response bytes (1 or 2) arriving from the UART receiver, with a response timeout. It sits between host logic and the host-side UART TX/RX pair.

## Interface
Parameters:
- TIMEOUT_CYCLES, 4096: cycles allowed between response bytes before abort; legal range ≥ 2.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-low
- CMD_VALID  in  1  command request
- CMD_READY  out  1  command accepted when CMD_VALID && CMD_READY
- CMD_TYPE  in  2  00 RF_WR, 01 RF_RD, 10 ALU_OP, 11 ALU_NOP
- CMD_ADDR  in  4  register-file address
- CMD_WDATA  in  8  register-file write data
- CMD_OP_A  in  8  ALU operand A
- CMD_OP_B  in  8  ALU operand B
- CMD_FUN  in  4  ALU function code
- TX_P_DATA  out  8  byte to transmitter
- TX_D_VLD  out  1  one-cycle byte strobe
- TX_BUSY  in  1  transmitter busy
- RX_P_DATA  in  8  received byte
- RX_D_VLD  in  1  received-byte strobe
- RSP_DATA  out  16  assembled response
- RSP_VALID  out  1  one-cycle pulse, RSP_DATA updated
- RSP_TIMEOUT  out  1  one-cycle pulse, response aborted

## Operation
- On acceptance, latch all CMD_* fields. Build the frame; 4-bit fields are zero-extended to 8 bits.
  - RF_WR: AA, {0,ADDR}, WDATA. No response.
  - RF_RD: BB, {0,ADDR}. 1 response byte; RSP_DATA = {8'h00, byte}.
  - ALU_OP: CC, OP_A, OP_B, {0,FUN}. 2 response bytes, LSB first; RSP_DATA = {byte2, byte1}.
  - ALU_NOP: DD, {0,FUN}. 2 response bytes as above.
- States:
  - IDLE: CMD_READY=1; moves to SEND on accept.
  - SEND: pulse TX_D_VLD with the current byte when TX_BUSY=0. Go to GAP, or after the last byte go to WAIT_RSP, or to IDLE for RF_WR.
  - GAP: one mandatory cycle, then back to SEND.
  - WAIT_RSP: collect bytes on RX_D_VLD. After the final byte go to IDLE, with RSP_DATA and RSP_VALID registered.
- 2-bit byte index and frame length 2–4. 1-bit response index.
- Timeout counter, width $clog2(TIMEOUT_CYCLES+1):
  - Cleared on entry to WAIT_RSP and on every RX byte.
  - Increments on each WAIT_RSP cycle without RX_D_VLD.
  - On reaching TIMEOUT_CYCLES: pulse RSP_TIMEOUT and return to IDLE. RSP_DATA keeps its previous value; partial bytes are discarded.
- RX_D_VLD outside WAIT_RSP (IDLE, SEND, GAP) is ignored.
- CMD_VALID while busy is not accepted. Fields are not sampled.
- Reset mid-frame: immediate return to IDLE. Frame abandoned, no further TX strobes.

## Timing
- Reset values:
  - State IDLE, so CMD_READY=1.
  - TX_P_DATA=0, TX_D_VLD=0.
  - RSP_DATA=0, RSP_VALID=0, RSP_TIMEOUT=0.
  - Counters 0.
- All outputs are registered except CMD_READY, which is decoded from state.
- First TX_D_VLD is in the cycle after acceptance, if TX_BUSY=0.
- Consecutive TX strobes are ≥2 cycles apart. The transmitter raises TX_BUSY the cycle after a strobe, and the GAP cycle covers that latency.
- TX_P_DATA is valid in the TX_D_VLD cycle and holds until the next strobe.
- Response path:
  - RSP_VALID follows the final RX_D_VLD by 1 cycle.
  - Next CMD accept is possible in that same cycle (state already IDLE).
  - RX_D_VLD in the cycle the counter would expire counts as a byte; no timeout.
- RF_WR: CMD_READY returns the cycle after the last strobe.

## Test plan
- RF_WR addr 4'h5, data 8'h3C, TX_BUSY low except 1 cycle after each strobe → TX bytes AA,05,3C; no RSP pulse; CMD_READY back after 3rd strobe.
- RF_RD addr 4'h2, RX returns 8'h7E → TX BB,02; RSP_DATA=16'h007E, RSP_VALID 1 cycle after the RX strobe.
- ALU_OP A=8'h10, B=8'h20, FUN=4'h0; RX 8'h30 then 8'h00 → TX CC,10,20,00; RSP_DATA=16'h0030.
- ALU_NOP FUN=4'h2 with TIMEOUT_CYCLES=16; RX sends 1 byte then silence → TX DD,02; RSP_TIMEOUT pulse 16 cycles after that byte; RSP_DATA unchanged; next command accepted.
- TX_BUSY held high 50 cycles mid-frame, stray RX_D_VLD during SEND, CMD_VALID while busy → byte order preserved, stray byte ignored, second command not latched.
- RST asserted between 2nd and 3rd byte of ALU_OP → all outputs at reset values; a fresh RF_RD after release completes normally.

Source files
------------

// File: rtl/host_cmd_master.sv
// Host-side command initiator: serialises one command into a UART byte frame,
// then gathers the 1- or 2-byte response with an inter-byte timeout.
module host_cmd_master #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [1:0]  CMD_TYPE,
    input  logic [3:0]  CMD_ADDR,
    input  logic [7:0]  CMD_WDATA,
    input  logic [7:0]  CMD_OP_A,
    input  logic [7:0]  CMD_OP_B,
    input  logic [3:0]  CMD_FUN,
    output logic [7:0]  TX_P_DATA,
    output logic        TX_D_VLD,
    input  logic        TX_BUSY,
    input  logic [7:0]  RX_P_DATA,
    input  logic        RX_D_VLD,
    output logic [15:0] RSP_DATA,
    output logic        RSP_VALID,
    output logic        RSP_TIMEOUT
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] TYPE_RF_WR  = 2'b00;
    localparam logic [1:0] TYPE_RF_RD  = 2'b01;
    localparam logic [1:0] TYPE_ALU_OP = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        WAIT_RSP
    } state_t;

    state_t            state_reg;
    logic [7:0]        frame_reg [4];
    logic [1:0]        byte_idx_reg;
    logic [1:0]        last_idx_reg;
    logic              has_rsp_reg;
    logic              rsp_two_reg;
    logic              rsp_idx_reg;
    logic [7:0]        rsp_lo_reg;
    logic [CNT_W-1:0]  tmo_cnt_reg;

    logic [7:0]        frame_next [4];
    logic [1:0]        last_idx_next;
    logic              has_rsp_next;
    logic              rsp_two_next;

    assign CMD_READY = (state_reg == IDLE);

    // Frame layout for the command currently on the request port.
    always_comb begin
        frame_next[0] = 8'h00;
        frame_next[1] = 8'h00;
        frame_next[2] = 8'h00;
        frame_next[3] = 8'h00;
        last_idx_next = 2'd1;
        has_rsp_next  = 1'b1;
        rsp_two_next  = 1'b1;
        case (CMD_TYPE)
            TYPE_RF_WR: begin
                frame_next[0] = 8'hAA;
                frame_next[1] = {4'h0, CMD_ADDR};
                frame_next[2] = CMD_WDATA;
                last_idx_next = 2'd2;
                has_rsp_next  = 1'b0;
                rsp_two_next  = 1'b0;
            end
            TYPE_RF_RD: begin
                frame_next[0] = 8'hBB;
                frame_next[1] = {4'h0, CMD_ADDR};
                last_idx_next = 2'd1;
                rsp_two_next  = 1'b0;
            end
            TYPE_ALU_OP: begin
                frame_next[0] = 8'hCC;
                frame_next[1] = CMD_OP_A;
                frame_next[2] = CMD_OP_B;
                frame_next[3] = {4'h0, CMD_FUN};
                last_idx_next = 2'd3;
            end
            default: begin
                frame_next[0] = 8'hDD;
                frame_next[1] = {4'h0, CMD_FUN};
                last_idx_next = 2'd1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg    <= IDLE;
            for (int i = 0; i < 4; i++) begin
                frame_reg[i] <= 8'h00;
            end
            byte_idx_reg <= 2'd0;
            last_idx_reg <= 2'd0;
            has_rsp_reg  <= 1'b0;
            rsp_two_reg  <= 1'b0;
            rsp_idx_reg  <= 1'b0;
            rsp_lo_reg   <= 8'h00;
            tmo_cnt_reg  <= '0;
            TX_P_DATA    <= 8'h00;
            TX_D_VLD     <= 1'b0;
            RSP_DATA     <= 16'h0000;
            RSP_VALID    <= 1'b0;
            RSP_TIMEOUT  <= 1'b0;
        end else begin
            TX_D_VLD    <= 1'b0;
            RSP_VALID   <= 1'b0;
            RSP_TIMEOUT <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (CMD_VALID) begin
                        for (int i = 0; i < 4; i++) begin
                            frame_reg[i] <= frame_next[i];
                        end
                        last_idx_reg <= last_idx_next;
                        has_rsp_reg  <= has_rsp_next;
                        rsp_two_reg  <= rsp_two_next;
                        byte_idx_reg <= 2'd0;
                        state_reg    <= SEND;
                    end
                end

                SEND: begin
                    if (!TX_BUSY) begin
                        TX_D_VLD  <= 1'b1;
                        TX_P_DATA <= frame_reg[byte_idx_reg];
                        if (byte_idx_reg == last_idx_reg) begin
                            byte_idx_reg <= 2'd0;
                            if (has_rsp_reg) begin
                                tmo_cnt_reg <= '0;
                                rsp_idx_reg <= 1'b0;
                                state_reg   <= WAIT_RSP;
                            end else begin
                                state_reg   <= IDLE;
                            end
                        end else begin
                            byte_idx_reg <= byte_idx_reg + 2'd1;
                            state_reg    <= GAP;
                        end
                    end
                end

                // Covers the transmitter's one-cycle delay in raising TX_BUSY.
                GAP: begin
                    state_reg <= SEND;
                end

                WAIT_RSP: begin
                    if (RX_D_VLD) begin
                        tmo_cnt_reg <= '0;
                        if (!rsp_two_reg || rsp_idx_reg) begin
                            RSP_DATA    <= rsp_two_reg ? {RX_P_DATA, rsp_lo_reg}
                                                       : {8'h00, RX_P_DATA};
                            RSP_VALID   <= 1'b1;
                            rsp_idx_reg <= 1'b0;
                            state_reg   <= IDLE;
                        end else begin
                            rsp_lo_reg  <= RX_P_DATA;
                            rsp_idx_reg <= 1'b1;
                        end
                    end else if (tmo_cnt_reg == CNT_LAST) begin
                        // This idle cycle brings the count to TIMEOUT_CYCLES;
                        // a partial response is dropped and RSP_DATA kept.
                        RSP_TIMEOUT <= 1'b1;
                        tmo_cnt_reg <= '0;
                        rsp_idx_reg <= 1'b0;
                        state_reg   <= IDLE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + CNT_ONE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_host_cmd_master.sv
// Directed bench for host_cmd_master: a frame/response model checked every
// cycle, plus literal expectations for the documented scenarios.
`timescale 1ns/1ps
module tb_host_cmd_master;

    localparam int TO = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [1:0]  CMD_TYPE = 2'b00;
    logic [3:0]  CMD_ADDR = 4'h0;
    logic [7:0]  CMD_WDATA = 8'h00;
    logic [7:0]  CMD_OP_A = 8'h00;
    logic [7:0]  CMD_OP_B = 8'h00;
    logic [3:0]  CMD_FUN = 4'h0;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_BUSY = 1'b0;
    logic [7:0]  RX_P_DATA = 8'h00;
    logic        RX_D_VLD = 1'b0;
    logic [15:0] RSP_DATA;
    logic        RSP_VALID;
    logic        RSP_TIMEOUT;

    host_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .CMD_VALID  (CMD_VALID),
        .CMD_READY  (CMD_READY),
        .CMD_TYPE   (CMD_TYPE),
        .CMD_ADDR   (CMD_ADDR),
        .CMD_WDATA  (CMD_WDATA),
        .CMD_OP_A   (CMD_OP_A),
        .CMD_OP_B   (CMD_OP_B),
        .CMD_FUN    (CMD_FUN),
        .TX_P_DATA  (TX_P_DATA),
        .TX_D_VLD   (TX_D_VLD),
        .TX_BUSY    (TX_BUSY),
        .RX_P_DATA  (RX_P_DATA),
        .RX_D_VLD   (RX_D_VLD),
        .RSP_DATA   (RSP_DATA),
        .RSP_VALID  (RSP_VALID),
        .RSP_TIMEOUT(RSP_TIMEOUT)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_cnt = 0;
    int rsp_cnt = 0;
    int to_cnt = 0;
    logic [7:0] tx_log [0:255];
    bit force_busy = 1'b0;

    // Model state
    logic [7:0]  m_txq [$];
    bit          m_busy, m_send, m_gap, m_wait, m_tx_vld, m_rsp_vld, m_rsp_to;
    bit          acc, n_tx_vld, n_rsp_vld, n_rsp_to;
    logic [7:0]  m_tx_data, m_lo;
    logic [15:0] m_rsp_data;
    int          m_need, m_got, m_idle;

    initial begin
        forever #5 CLK = ~CLK;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
        $fatal(1);
    end

    task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Transmitter model: busy for exactly the cycle after each strobe, plus a forced window.
    initial begin
        bit seen;
        seen = 1'b0;
        forever begin
            @(negedge CLK);
            seen = TX_D_VLD;
            @(posedge CLK);
            #1;
            TX_BUSY = seen || force_busy;
        end
    end

    task automatic model_reset();
        m_txq.delete();
        m_busy = 0; m_send = 0; m_gap = 0; m_wait = 0;
        m_tx_vld = 0; m_rsp_vld = 0; m_rsp_to = 0;
        m_tx_data = 8'h00; m_lo = 8'h00; m_rsp_data = 16'h0000;
        m_need = 0; m_got = 0; m_idle = 0;
    endtask

    // Model update and per-cycle comparison.
    initial begin
        model_reset();
        forever begin
            @(negedge CLK);
            if (!RST) begin
                check_val("reset_cmd_ready", CMD_READY, 1'b1);
                check_val("reset_tx_vld", TX_D_VLD, 1'b0);
                check_val("reset_tx_data", TX_P_DATA, 8'h00);
                check_val("reset_rsp_data", RSP_DATA, 16'h0000);
                check_val("reset_rsp_valid", RSP_VALID, 1'b0);
                check_val("reset_rsp_timeout", RSP_TIMEOUT, 1'b0);
                model_reset();
            end else begin
                check_val("cmd_ready", CMD_READY, !m_busy);
                check_val("tx_d_vld", TX_D_VLD, m_tx_vld);
                check_val("tx_p_data", TX_P_DATA, m_tx_data);
                check_val("rsp_valid", RSP_VALID, m_rsp_vld);
                check_val("rsp_timeout", RSP_TIMEOUT, m_rsp_to);
                check_val("rsp_data", RSP_DATA, m_rsp_data);
                if (TX_D_VLD) begin
                    tx_log[strobe_cnt % 256] = TX_P_DATA;
                    strobe_cnt++;
                end
                if (RSP_VALID) begin
                    rsp_cnt++;
                    $display("RSP data=%h", RSP_DATA);
                end
                if (RSP_TIMEOUT) begin
                    to_cnt++;
                    $display("RSP timeout, data held at %h", RSP_DATA);
                end

                acc = CMD_VALID && !m_busy;
                n_tx_vld = 0; n_rsp_vld = 0; n_rsp_to = 0;

                if (m_wait) begin
                    if (RX_D_VLD) begin
                        m_idle = 0;
                        if (m_got == 0) m_lo = RX_P_DATA;
                        m_got++;
                        if (m_got == m_need) begin
                            n_rsp_vld = 1;
                            m_rsp_data = (m_need == 1) ? {8'h00, RX_P_DATA} : {RX_P_DATA, m_lo};
                            m_wait = 0;
                            m_busy = 0;
                        end
                    end else begin
                        m_idle++;
                        if (m_idle == TO) begin
                            n_rsp_to = 1;
                            m_wait = 0;
                            m_busy = 0;
                        end
                    end
                end

                if (m_send && !TX_BUSY) begin
                    n_tx_vld = 1;
                    m_tx_data = m_txq.pop_front();
                    m_send = 0;
                    if (m_txq.size() == 0) begin
                        if (m_need == 0) begin
                            m_busy = 0;
                        end else begin
                            m_wait = 1; m_idle = 0; m_got = 0;
                        end
                    end else begin
                        m_gap = 1;
                    end
                end else if (m_gap) begin
                    m_gap = 0;
                    m_send = 1;
                end

                if (acc) begin
                    m_busy = 1;
                    m_send = 1;
                    case (CMD_TYPE)
                        2'b00: begin
                            m_txq.push_back(8'hAA); m_txq.push_back({4'h0, CMD_ADDR});
                            m_txq.push_back(CMD_WDATA); m_need = 0;
                        end
                        2'b01: begin
                            m_txq.push_back(8'hBB); m_txq.push_back({4'h0, CMD_ADDR}); m_need = 1;
                        end
                        2'b10: begin
                            m_txq.push_back(8'hCC); m_txq.push_back(CMD_OP_A);
                            m_txq.push_back(CMD_OP_B); m_txq.push_back({4'h0, CMD_FUN}); m_need = 2;
                        end
                        default: begin
                            m_txq.push_back(8'hDD); m_txq.push_back({4'h0, CMD_FUN}); m_need = 2;
                        end
                    endcase
                end

                m_tx_vld = n_tx_vld;
                m_rsp_vld = n_rsp_vld;
                m_rsp_to = n_rsp_to;
            end
        end
    end

    task automatic send_cmd(input logic [1:0] t, input logic [3:0] addr, input logic [7:0] wdata,
                            input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun);
        bit took;
        int k;
        CMD_TYPE = t; CMD_ADDR = addr; CMD_WDATA = wdata;
        CMD_OP_A = a; CMD_OP_B = b; CMD_FUN = fun;
        CMD_VALID = 1'b1;
        took = 1'b0;
        k = 0;
        while (!took && k < 200) begin
            took = CMD_READY;
            tick();
            k++;
        end
        CMD_VALID = 1'b0;
        CMD_TYPE = 2'($urandom); CMD_ADDR = 4'($urandom); CMD_WDATA = 8'($urandom);
        CMD_OP_A = 8'($urandom); CMD_OP_B = 8'($urandom); CMD_FUN = 4'($urandom);
        check_val("cmd_accept", took, 1'b1);
        $display("CMD type=%0d addr=%h wdata=%h a=%h b=%h fun=%h", t, addr, wdata, a, b, fun);
    endtask

    task automatic wait_strobes(input int target);
        int k;
        k = 0;
        while (strobe_cnt < target && k < 300) begin
            tick();
            k++;
        end
        check_val("strobe_wait", strobe_cnt >= target, 1'b1);
    endtask

    task automatic rx_byte(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        RX_P_DATA = b;
        RX_D_VLD = 1'b1;
        tick();
        RX_D_VLD = 1'b0;
    endtask

    initial begin
        int base;
        int r0;
        int t0;
        int k;

        // Reset state
        repeat (3) tick();
        check_val("lit_reset_ready", CMD_READY, 1'b1);
        check_val("lit_reset_rsp", RSP_DATA, 16'h0000);
        RST = 1'b1;
        tick();

        // RF_WR: AA 05 3C, no response
        base = strobe_cnt; r0 = rsp_cnt; t0 = to_cnt;
        send_cmd(2'b00, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0);
        wait_strobes(base + 3);
        check_val("wr_b0", tx_log[base % 256], 8'hAA);
        check_val("wr_b1", tx_log[(base + 1) % 256], 8'h05);
        check_val("wr_b2", tx_log[(base + 2) % 256], 8'h3C);
        check_val("wr_ready_back", CMD_READY, 1'b1);
        repeat (20) tick();
        check_val("wr_no_rsp", 16'(rsp_cnt - r0), 16'd0);
        check_val("wr_no_timeout", 16'(to_cnt - t0), 16'd0);

        // RF_RD: BB 02, response 7E
        base = strobe_cnt;
        send_cmd(2'b01, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0);
        wait_strobes(base + 2);
        check_val("rd_b0", tx_log[base % 256], 8'hBB);
        check_val("rd_b1", tx_log[(base + 1) % 256], 8'h02);
        rx_byte(8'h7E, 2);
        check_val("rd_rsp_valid", RSP_VALID, 1'b1);
        check_val("rd_rsp_data", RSP_DATA, 16'h007E);

        // ALU_OP: CC 10 20 00, response 30 then 00
        base = strobe_cnt;
        send_cmd(2'b10, 4'h0, 8'h00, 8'h10, 8'h20, 4'h0);
        wait_strobes(base + 4);
        check_val("op_b0", tx_log[base % 256], 8'hCC);
        check_val("op_b1", tx_log[(base + 1) % 256], 8'h10);
        check_val("op_b2", tx_log[(base + 2) % 256], 8'h20);
        check_val("op_b3", tx_log[(base + 3) % 256], 8'h00);
        rx_byte(8'h30, 1);
        rx_byte(8'h00, 1);
        check_val("op_rsp_valid", RSP_VALID, 1'b1);
        check_val("op_rsp_data", RSP_DATA, 16'h0030);

        // ALU_NOP with one response byte then silence: timeout
        base = strobe_cnt;
        send_cmd(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2);
        wait_strobes(base + 2);
        check_val("nop_b0", tx_log[base % 256], 8'hDD);
        check_val("nop_b1", tx_log[(base + 1) % 256], 8'h02);
        rx_byte(8'h55, 2);
        k = 1;
        while (!RSP_TIMEOUT && k < 40) begin
            tick();
            k++;
        end
        check_val("nop_timeout_delay", 16'(k), 16'd17);
        check_val("nop_timeout_data_held", RSP_DATA, 16'h0030);
        base = strobe_cnt;
        send_cmd(2'b00, 4'hF, 8'h81, 8'h00, 8'h00, 4'h0);
        wait_strobes(base + 3);
        check_val("after_to_b1", tx_log[(base + 1) % 256], 8'h0F);
        check_val("after_to_b2", tx_log[(base + 2) % 256], 8'h81);

        // Long TX_BUSY stall, stray RX byte, CMD_VALID while busy
        base = strobe_cnt;
        send_cmd(2'b10, 4'h0, 8'h00, 8'h5A, 8'hC3, 4'h7);
        wait_strobes(base + 1);
        force_busy = 1'b1;
        tick();
        rx_byte(8'hEE, 2);
        CMD_TYPE = 2'b00; CMD_ADDR = 4'h1; CMD_WDATA = 8'h99; CMD_VALID = 1'b1;
        repeat (5) tick();
        CMD_VALID = 1'b0;
        repeat (40) tick();
        force_busy = 1'b0;
        wait_strobes(base + 4);
        check_val("stall_b0", tx_log[base % 256], 8'hCC);
        check_val("stall_b1", tx_log[(base + 1) % 256], 8'h5A);
        check_val("stall_b2", tx_log[(base + 2) % 256], 8'hC3);
        check_val("stall_b3", tx_log[(base + 3) % 256], 8'h07);
        rx_byte(8'h12, 1);
        rx_byte(8'h34, 3);
        check_val("stall_rsp_data", RSP_DATA, 16'h3412);
        repeat (5) tick();
        check_val("stall_no_extra_frame", 16'(strobe_cnt - base), 16'd4);

        // Reset between 2nd and 3rd byte of ALU_OP
        base = strobe_cnt;
        send_cmd(2'b10, 4'h0, 8'h00, 8'h11, 8'h22, 4'h3);
        wait_strobes(base + 2);
        RST = 1'b0;
        #1;
        check_val("mid_rst_ready", CMD_READY, 1'b1);
        check_val("mid_rst_tx_vld", TX_D_VLD, 1'b0);
        check_val("mid_rst_tx_data", TX_P_DATA, 8'h00);
        check_val("mid_rst_rsp_data", RSP_DATA, 16'h0000);
        repeat (3) tick();
        RST = 1'b1;
        repeat (10) tick();
        check_val("mid_rst_no_more_tx", 16'(strobe_cnt - base), 16'd2);
        base = strobe_cnt;
        send_cmd(2'b01, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0);
        wait_strobes(base + 2);
        check_val("post_rst_b0", tx_log[base % 256], 8'hBB);
        check_val("post_rst_b1", tx_log[(base + 1) % 256], 8'h09);
        rx_byte(8'hA5, 1);
        check_val("post_rst_rsp_valid", RSP_VALID, 1'b1);
        check_val("post_rst_rsp_data", RSP_DATA, 16'h00A5);

        // ALU_NOP with full 2-byte response
        base = strobe_cnt;
        send_cmd(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'hB);
        wait_strobes(base + 2);
        check_val("nop2_b1", tx_log[(base + 1) % 256], 8'h0B);
        rx_byte(8'hEF, 3);
        rx_byte(8'hBE, 2);
        check_val("nop2_rsp_data", RSP_DATA, 16'hBEEF);
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
